// File: rtl/spi_shifter.sv
// SPI mode-0 master shifter: single/dual/quad data lines, 1..4 byte commands,
// optional read capture returned right-aligned through a valid/ready port.
module spi_shifter #(
    parameter int DW = 4,
    parameter int SN = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    cfg_div,
    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic [31:0]   cmd_dat,
    input  logic [1:0]    cmd_len,
    input  logic [1:0]    cmd_iom,
    input  logic          cmd_oen,
    input  logic          cmd_ien,
    input  logic [SN-1:0] cmd_ssn,
    input  logic          cmd_end,
    output logic          rdt_vld,
    input  logic          rdt_rdy,
    output logic [31:0]   rdt_dat,
    input  logic          sck_i,
    output logic          sck_o,
    output logic          sck_t,
    input  logic [DW-1:0] sio_i,
    output logic [DW-1:0] sio_o,
    output logic [DW-1:0] sio_t,
    input  logic [SN-1:0] ssn_i,
    output logic [SN-1:0] ssn_o,
    output logic [SN-1:0] ssn_t
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_HI,
        ST_LO,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_DUAL   = 2'd1;
    localparam logic [1:0] MODE_QUAD   = 2'd2;

    localparam logic [3:0] SIO_O_IDLE = 4'b1100;
    localparam logic [3:0] SIO_T_IDLE = 4'b0011;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    div_q, div_d;
    logic [5:0]    per_q, per_d;
    logic [1:0]    mode_q, mode_d;
    logic          oen_q, oen_d;
    logic          ien_q, ien_d;
    logic          end_q, end_d;
    logic [31:0]   tx_q, tx_d;
    logic [31:0]   rx_q, rx_d;
    logic          sck_q, sck_d;
    logic [3:0]    sio_o_q, sio_o_d;
    logic [3:0]    sio_t_q, sio_t_d;
    logic [SN-1:0] ssn_q, ssn_d;
    logic          rdy_q, rdy_d;
    logic          rvld_q, rvld_d;
    logic [31:0]   rdat_q, rdat_d;

    logic          accept;
    logic [1:0]    cmd_mode;
    logic [31:0]   tx_shift;
    logic          unused_inputs;

    // Data bits go out on the highest-numbered active line first.
    function automatic logic [3:0] drive_bits(input logic [31:0] tx, input logic [1:0] mode);
        case (mode)
            MODE_SINGLE: return {2'b11, 1'b0, tx[31]};
            MODE_DUAL:   return {2'b11, tx[31:30]};
            default:     return tx[31:28];
        endcase
    endfunction

    function automatic logic [3:0] tri_bits(input logic [1:0] mode, input logic oen);
        case (mode)
            MODE_SINGLE: return {1'b0, 1'b0, 1'b1, ~oen};
            MODE_DUAL:   return {1'b0, 1'b0, ~oen, ~oen};
            default:     return {4{~oen}};
        endcase
    endfunction

    function automatic logic [31:0] shift_tx(input logic [31:0] tx, input logic [1:0] mode);
        case (mode)
            MODE_SINGLE: return {tx[30:0], 1'b0};
            MODE_DUAL:   return {tx[29:0], 2'b00};
            default:     return {tx[27:0], 4'b0000};
        endcase
    endfunction

    function automatic logic [31:0] shift_rx(input logic [31:0] rx, input logic [1:0] mode,
                                             input logic [3:0] sin);
        case (mode)
            MODE_SINGLE: return {rx[30:0], sin[1]};
            MODE_DUAL:   return {rx[29:0], sin[1:0]};
            default:     return {rx[27:0], sin};
        endcase
    endfunction

    function automatic logic [5:0] periods(input logic [1:0] len, input logic [1:0] mode);
        logic [5:0] nbytes;
        nbytes = {4'b0000, len} + 6'd1;
        case (mode)
            MODE_SINGLE: return nbytes << 3;
            MODE_DUAL:   return nbytes << 2;
            default:     return nbytes << 1;
        endcase
    endfunction

    assign cmd_mode = (cmd_iom == 2'b11) ? MODE_QUAD : cmd_iom;
    assign accept   = cmd_vld && rdy_q;
    assign tx_shift = shift_tx(tx_q, mode_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        per_d   = per_q;
        mode_d  = mode_q;
        oen_d   = oen_q;
        ien_d   = ien_q;
        end_d   = end_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        sio_o_d = sio_o_q;
        sio_t_d = sio_t_q;
        ssn_d   = ssn_q;
        rvld_d  = rvld_q;
        rdat_d  = rdat_q;

        if (rvld_q && rdt_rdy) begin
            rvld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (accept) begin
                    div_d   = cfg_div;
                    cnt_d   = cfg_div;
                    mode_d  = cmd_mode;
                    oen_d   = cmd_oen;
                    ien_d   = cmd_ien;
                    end_d   = cmd_end;
                    tx_d    = cmd_dat;
                    rx_d    = '0;
                    per_d   = periods(cmd_len, cmd_mode);
                    sck_d   = 1'b0;
                    sio_o_d = drive_bits(cmd_dat, cmd_mode);
                    sio_t_d = tri_bits(cmd_mode, cmd_oen);
                    // A held select is kept as-is; only a fresh transfer picks a slave.
                    if (state_q == ST_IDLE) begin
                        ssn_d   = ~cmd_ssn;
                        state_d = ST_SEL;
                    end else begin
                        state_d = ST_LO;
                    end
                end
            end
            ST_SEL, ST_LO: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = ST_HI;
                    cnt_d   = div_q;
                    sck_d   = 1'b1;
                    per_d   = per_q - 6'd1;
                    if (ien_q) begin
                        rx_d = shift_rx(rx_q, mode_q, sio_i[3:0]);
                    end
                end
            end
            ST_HI: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    cnt_d = div_q;
                    sck_d = 1'b0;
                    if (per_q == 6'd0) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LO;
                        tx_d    = tx_shift;
                        sio_o_d = drive_bits(tx_shift, mode_q);
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    if (ien_q) begin
                        rvld_d = 1'b1;
                        rdat_d = rx_q;
                    end
                    if (end_q) begin
                        state_d = ST_IDLE;
                        ssn_d   = '1;
                        sio_o_d = SIO_O_IDLE;
                        sio_t_d = SIO_T_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rdy_d = ((state_d == ST_IDLE) || (state_d == ST_WAIT)) && !rvld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            per_q   <= '0;
            mode_q  <= MODE_SINGLE;
            oen_q   <= 1'b0;
            ien_q   <= 1'b0;
            end_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            sio_o_q <= SIO_O_IDLE;
            sio_t_q <= SIO_T_IDLE;
            ssn_q   <= '1;
            rdy_q   <= 1'b0;
            rvld_q  <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            oen_q   <= oen_d;
            ien_q   <= ien_d;
            end_q   <= end_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            sio_o_q <= sio_o_d;
            sio_t_q <= sio_t_d;
            ssn_q   <= ssn_d;
            rdy_q   <= rdy_d;
            rvld_q  <= rvld_d;
            rdat_q  <= rdat_d;
        end
    end

    // The master always drives SCK and the selects; their inputs are not observed.
    assign sck_t         = 1'b0;
    assign ssn_t         = '0;
    assign unused_inputs = ^{sck_i, ssn_i};

    assign sck_o   = sck_q;
    assign sio_o   = sio_o_q;
    assign sio_t   = sio_t_q;
    assign ssn_o   = ssn_q;
    assign cmd_rdy = rdy_q;
    assign rdt_vld = rvld_q;
    assign rdt_dat = rdat_q;

endmodule

// File: tb/tb_spi_shifter.sv
// Directed bench for spi_shifter: pin-level SCK/SIO/SSN sequences, read capture,
// read-data backpressure, select hold across commands and reset behaviour.
module tb_spi_shifter;
    localparam int DW = 4;
    localparam int SN = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    cfg_div = '0;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy;
    logic [31:0]   cmd_dat = '0;
    logic [1:0]    cmd_len = '0;
    logic [1:0]    cmd_iom = '0;
    logic          cmd_oen = 1'b0;
    logic          cmd_ien = 1'b0;
    logic [SN-1:0] cmd_ssn = '0;
    logic          cmd_end = 1'b0;
    logic          rdt_vld;
    logic          rdt_rdy = 1'b0;
    logic [31:0]   rdt_dat;
    logic          sck_i = 1'b0;
    logic          sck_o;
    logic          sck_t;
    logic [DW-1:0] sio_i;
    logic [DW-1:0] sio_o;
    logic [DW-1:0] sio_t;
    logic [SN-1:0] ssn_i = '1;
    logic [SN-1:0] ssn_o;
    logic [SN-1:0] ssn_t;

    int vectors = 0;
    int miscompares = 0;

    spi_shifter #(.DW(DW), .SN(SN)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_dat(cmd_dat), .cmd_len(cmd_len),
        .cmd_iom(cmd_iom), .cmd_oen(cmd_oen), .cmd_ien(cmd_ien), .cmd_ssn(cmd_ssn),
        .cmd_end(cmd_end), .rdt_vld(rdt_vld), .rdt_rdy(rdt_rdy), .rdt_dat(rdt_dat),
        .sck_i(sck_i), .sck_o(sck_o), .sck_t(sck_t),
        .sio_i(sio_i), .sio_o(sio_o), .sio_t(sio_t),
        .ssn_i(ssn_i), .ssn_o(ssn_o), .ssn_t(ssn_t)
    );

    always #5 clk = ~clk;

    // Slave model: presents the next nibble after every SCK falling edge.
    logic [3:0] slave_nib [0:7];
    int rd_idx = 0;
    always @(negedge sck_o) rd_idx = rd_idx + 1;
    assign sio_i = (rd_idx >= 0 && rd_idx < 8) ? slave_nib[rd_idx] : 4'h0;

    int         mon_pulses, mon_hi_min, mon_hi_max, mon_lo_min, mon_lo_max;
    logic [3:0] mon_sio [0:31];
    logic [7:0] mon_ssn_hi;
    logic [3:0] mon_siot_hi;
    logic       mon_timeout;

    task automatic load_slave(input logic [31:0] nibs);
        for (int i = 0; i < 8; i++) slave_nib[i] = nibs[31-4*i -: 4];
        rd_idx = 0;
    endtask

    task automatic send_cmd(input logic [7:0] div, input logic [31:0] dat, input logic [1:0] len,
                            input logic [1:0] iom, input logic oen, input logic ien,
                            input logic [7:0] ssn, input logic en);
        int w = 0;
        while (cmd_rdy !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_accept: cmd_rdy=%b after %0d cycles, required 1", cmd_rdy, w);
        end
        cfg_div = div; cmd_dat = dat; cmd_len = len; cmd_iom = iom;
        cmd_oen = oen; cmd_ien = ien; cmd_ssn = ssn; cmd_end = en;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    // Samples at negedges until the transfer finishes (ready or read data returns).
    task automatic monitor_xfer(input int max_cyc);
        logic prev = 1'b0;
        int   hi_run = 0;
        int   lo_run = 0;
        bit   done = 0;
        mon_pulses = 0; mon_timeout = 1'b1;
        mon_hi_min = 1000; mon_hi_max = 0; mon_lo_min = 1000; mon_lo_max = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            if (sck_o && !prev) begin
                if (mon_pulses > 0) begin
                    if (lo_run < mon_lo_min) mon_lo_min = lo_run;
                    if (lo_run > mon_lo_max) mon_lo_max = lo_run;
                end
                if (mon_pulses == 0) begin
                    mon_ssn_hi = ssn_o;
                    mon_siot_hi = sio_t;
                end
                if (mon_pulses < 32) mon_sio[mon_pulses] = sio_o;
                mon_pulses++;
                hi_run = 0;
            end
            if (!sck_o && prev) begin
                if (hi_run < mon_hi_min) mon_hi_min = hi_run;
                if (hi_run > mon_hi_max) mon_hi_max = hi_run;
                lo_run = 0;
            end
            if (sck_o) hi_run++; else lo_run++;
            prev = sck_o;
            if (mon_pulses > 0 && !sck_o && (cmd_rdy || rdt_vld)) begin
                done = 1;
                mon_timeout = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sck_o, sck_t, ssn_o, ssn_t, sio_o, sio_t, cmd_rdy, rdt_vld, rdt_dat} !==
            {1'b0, 1'b0, 8'hFF, 8'h00, 4'hC, 4'h3, 1'b0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_values: sck=%b sckt=%b ssn=%h ssnt=%h sio=%h siot=%h rdy=%b vld=%b dat=%h, required 0 0 ff 00 c 3 0 0 00000000",
                     sck_o, sck_t, ssn_o, ssn_t, sio_o, sio_t, cmd_rdy, rdt_vld, rdt_dat);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy_release: got %b, required 0", cmd_rdy); end
        @(negedge clk);
        vectors++;
        if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy_first_clk: got %b, required 1", cmd_rdy); end
        $display("test_reset done");
    endtask

    task automatic test_single_write;
        logic [7:0] got = '0;
        send_cmd(8'd0, 32'hA55A3CF0, 2'd0, 2'b00, 1'b1, 1'b0, 8'h01, 1'b1);
        monitor_xfer(200);
        for (int i = 0; i < 8; i++) got = {got[6:0], mon_sio[i][0]};
        vectors++;
        if (mon_timeout !== 1'b0) begin miscompares++; $display("FAIL sw_timeout: transfer did not finish"); end
        vectors++;
        if (mon_pulses !== 8) begin miscompares++; $display("FAIL sw_pulses: got %0d, required 8", mon_pulses); end
        vectors++;
        if (got !== 8'hA5) begin miscompares++; $display("FAIL sw_mosi: got %h, required a5", got); end
        vectors++;
        if (mon_hi_min !== 1 || mon_hi_max !== 1 || mon_lo_min !== 1 || mon_lo_max !== 1) begin
            miscompares++;
            $display("FAIL sw_sck_phase: hi %0d..%0d lo %0d..%0d, required all 1", mon_hi_min, mon_hi_max, mon_lo_min, mon_lo_max);
        end
        vectors++;
        if (mon_ssn_hi !== 8'hFE) begin miscompares++; $display("FAIL sw_ssn_active: got %h, required fe", mon_ssn_hi); end
        vectors++;
        if (mon_siot_hi !== 4'b0010) begin miscompares++; $display("FAIL sw_sio_t: got %b, required 0010", mon_siot_hi); end
        vectors++;
        if (mon_sio[0][3:2] !== 2'b11) begin miscompares++; $display("FAIL sw_hold_wp: got %b, required 11", mon_sio[0][3:2]); end
        vectors++;
        if (ssn_o !== 8'hFF || rdt_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_release: ssn=%h vld=%b, required ff 0", ssn_o, rdt_vld);
        end
        $display("test_single_write done: mosi=%h pulses=%0d", got, mon_pulses);
    endtask

    task automatic test_quad_read;
        load_slave(32'h1234_0000);
        send_cmd(8'd0, 32'hFFFFFFFF, 2'd1, 2'b11, 1'b0, 1'b1, 8'h02, 1'b1);
        monitor_xfer(200);
        vectors++;
        if (mon_timeout !== 1'b0 || mon_pulses !== 4) begin
            miscompares++;
            $display("FAIL qr_pulses: got %0d (timeout=%b), required 4", mon_pulses, mon_timeout);
        end
        vectors++;
        if (mon_siot_hi !== 4'hF || mon_ssn_hi !== 8'hFD) begin
            miscompares++;
            $display("FAIL qr_pins: sio_t=%h ssn=%h, required f fd", mon_siot_hi, mon_ssn_hi);
        end
        vectors++;
        if (rdt_vld !== 1'b1 || rdt_dat !== 32'h00001234) begin
            miscompares++;
            $display("FAIL qr_rdata: vld=%b dat=%h, required 1 00001234", rdt_vld, rdt_dat);
        end
        vectors++;
        if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL qr_rdy_blocked: got %b, required 0", cmd_rdy); end
        rdt_rdy = 1'b1;
        @(negedge clk);
        rdt_rdy = 1'b0;
        vectors++;
        if (rdt_vld !== 1'b0 || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL qr_handshake: vld=%b rdy=%b, required 0 1", rdt_vld, cmd_rdy);
        end
        $display("test_quad_read done: rdt_dat=%h", rdt_dat);
    endtask

    task automatic test_back_to_back;
        logic [7:0] got = '0;
        send_cmd(8'd1, 32'h3C000000, 2'd0, 2'b00, 1'b1, 1'b0, 8'h04, 1'b0);
        monitor_xfer(300);
        for (int i = 0; i < 8; i++) got = {got[6:0], mon_sio[i][0]};
        vectors++;
        if (mon_timeout !== 1'b0 || got !== 8'h3C) begin
            miscompares++;
            $display("FAIL b2b_first_data: got %h (timeout=%b), required 3c", got, mon_timeout);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (ssn_o !== 8'hFB || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_wait_hold: ssn=%h rdy=%b, required fb 1", ssn_o, cmd_rdy);
        end
        send_cmd(8'd1, 32'hA5000000, 2'd0, 2'b10, 1'b1, 1'b0, 8'h10, 1'b1);
        vectors++;
        if (ssn_o !== 8'hFB || sck_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_reselect: ssn=%h sck=%b, required fb 0", ssn_o, sck_o);
        end
        monitor_xfer(300);
        vectors++;
        if (mon_pulses !== 2 || mon_sio[0] !== 4'hA || mon_sio[1] !== 4'h5) begin
            miscompares++;
            $display("FAIL b2b_quad_data: pulses=%0d nib=%h,%h, required 2 a,5", mon_pulses, mon_sio[0], mon_sio[1]);
        end
        vectors++;
        if (mon_ssn_hi !== 8'hFB || mon_siot_hi !== 4'h0) begin
            miscompares++;
            $display("FAIL b2b_second_pins: ssn=%h sio_t=%h, required fb 0", mon_ssn_hi, mon_siot_hi);
        end
        vectors++;
        if (ssn_o !== 8'hFF) begin miscompares++; $display("FAIL b2b_release: got %h, required ff", ssn_o); end
        $display("test_back_to_back done");
    endtask

    task automatic test_div3;
        logic [7:0] got = '0;
        send_cmd(8'd3, 32'h81000000, 2'd0, 2'b00, 1'b1, 1'b0, 8'h80, 1'b1);
        monitor_xfer(400);
        for (int i = 0; i < 8; i++) got = {got[6:0], mon_sio[i][0]};
        vectors++;
        if (mon_pulses !== 8 || got !== 8'h81) begin
            miscompares++;
            $display("FAIL div3_data: pulses=%0d mosi=%h, required 8 81", mon_pulses, got);
        end
        vectors++;
        if (mon_hi_min !== 4 || mon_hi_max !== 4) begin
            miscompares++;
            $display("FAIL div3_high: %0d..%0d, required 4", mon_hi_min, mon_hi_max);
        end
        vectors++;
        if (mon_lo_min !== 4 || mon_lo_max !== 4) begin
            miscompares++;
            $display("FAIL div3_low: %0d..%0d, required 4", mon_lo_min, mon_lo_max);
        end
        $display("test_div3 done");
    endtask

    task automatic test_rdt_stall;
        logic [7:0] got = '0;
        load_slave(32'h2130_0000);
        send_cmd(8'd0, 32'h5A000000, 2'd0, 2'b01, 1'b1, 1'b1, 8'h08, 1'b1);
        monitor_xfer(200);
        for (int i = 0; i < 4; i++) got = {got[5:0], mon_sio[i][1:0]};
        vectors++;
        if (mon_pulses !== 4 || got !== 8'h5A || mon_siot_hi !== 4'h0) begin
            miscompares++;
            $display("FAIL stall_dual_out: pulses=%0d data=%h sio_t=%h, required 4 5a 0", mon_pulses, got, mon_siot_hi);
        end
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (rdt_vld !== 1'b1 || rdt_dat !== 32'h0000009C || cmd_rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_cycle%0d: vld=%b dat=%h rdy=%b, required 1 0000009c 0", i, rdt_vld, rdt_dat, cmd_rdy);
            end
            @(negedge clk);
        end
        rdt_rdy = 1'b1;
        @(negedge clk);
        rdt_rdy = 1'b0;
        vectors++;
        if (rdt_vld !== 1'b0 || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: vld=%b rdy=%b, required 0 1", rdt_vld, cmd_rdy);
        end
        $display("test_rdt_stall done");
    endtask

    task automatic test_reset_mid;
        int   pulses = 0;
        int   bad_vld = 0;
        int   bad_sck = 0;
        logic prev = 1'b0;
        load_slave(32'hFFFF_FFFF);
        send_cmd(8'd2, 32'hC3960000, 2'd1, 2'b01, 1'b1, 1'b1, 8'h20, 1'b1);
        for (int i = 0; i < 300 && pulses < 3; i++) begin
            @(negedge clk);
            if (sck_o && !prev) pulses++;
            prev = sck_o;
        end
        vectors++;
        if (pulses !== 3) begin miscompares++; $display("FAIL rstmid_reach: got %0d pulses, required 3", pulses); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({sck_o, sck_t, ssn_o, ssn_t, sio_o, sio_t, cmd_rdy, rdt_vld, rdt_dat} !==
            {1'b0, 1'b0, 8'hFF, 8'h00, 4'hC, 4'h3, 1'b0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL rstmid_async: sck=%b sckt=%b ssn=%h ssnt=%h sio=%h siot=%h rdy=%b vld=%b dat=%h, required 0 0 ff 00 c 3 0 0 00000000",
                     sck_o, sck_t, ssn_o, ssn_t, sio_o, sio_t, cmd_rdy, rdt_vld, rdt_dat);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (sck_o !== 1'b0 || ssn_o !== 8'hFF || cmd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_held: sck=%b ssn=%h rdy=%b, required 0 ff 0", sck_o, ssn_o, cmd_rdy);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL rstmid_rdy_release: got %b, required 0", cmd_rdy); end
        @(negedge clk);
        vectors++;
        if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL rstmid_rdy_first_clk: got %b, required 1", cmd_rdy); end
        for (int i = 0; i < 30; i++) begin
            if (rdt_vld !== 1'b0) bad_vld++;
            if (sck_o !== 1'b0) bad_sck++;
            @(negedge clk);
        end
        vectors++;
        if (bad_vld !== 0 || bad_sck !== 0) begin
            miscompares++;
            $display("FAIL rstmid_aborted: vld cycles=%0d sck cycles=%0d, required 0 0", bad_vld, bad_sck);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) slave_nib[i] = 4'h0;
        test_reset();
        test_single_write();
        test_quad_read();
        test_back_to_back();
        test_div3();
        test_rdt_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_shifter.md
SPI_SHIFTER -- requirements
Module: spi_shifter

Interface
REQ-001 Parameter DW, default 4, number of SPI data IO lines, fixed to 4: sio[3:0] = {HOLD#, WP#, MISO, MOSI}.
REQ-002 Parameter SN, default 8, number of slave select lines.
REQ-003 clk  input  1  single clock; every register is in this domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cfg_div  input  8  SCK half-period is cfg_div+1 clk cycles; sampled at command accept.
REQ-006 cmd_vld / cmd_rdy  input / output  1 / 1  command handshake; transfer when both high on a clk edge.
REQ-007 cmd_dat  input  32  write data, MSB-first, left-aligned.
REQ-008 cmd_len  input  2  transfer length in bytes minus one (1..4 bytes).
REQ-009 cmd_iom  input  2  IO mode: 00 single, 01 dual, 10 quad; 11 is treated as quad.
REQ-010 cmd_oen, cmd_ien  input  1 each  drive data / capture read data.
REQ-011 cmd_ssn  input  SN  one-hot select of the target slave.
REQ-012 cmd_end  input  1  release slave select after this command.
REQ-013 rdt_vld / rdt_rdy / rdt_dat  output / input / output  1 / 1 / 32  read-data handshake; data right-aligned.
REQ-014 Master-side SPI pins: sck_i/o/t (1), sio_i/o/t (DW), ssn_i/o/t (SN); a *_t bit high means that pin is high-impedance; sck_i and ssn_i are unused.

Function
REQ-015 SPI mode 0 only:
  - SCK idles low.
  - Outputs change on the SCK falling edge; inputs are sampled on the rising edge.
REQ-016 Bits per SCK period W = 1/2/4 for single/dual/quad; SCK periods per command N = 8*(cmd_len+1)/W.
REQ-017 FSM states: IDLE, SEL, HI, LO, HOLD, WAIT.
REQ-018 A half-period counter reloads to cfg_div on every state entry; a state lasts cfg_div+1 cycles unless stated otherwise.
REQ-019 cmd_rdy is high only in IDLE, and in WAIT while rdt_vld=0.
REQ-020 On accept in IDLE, the next cycle is SEL:
  - ssn_o = ~cmd_ssn; ssn_t = 0.
  - First W data bits driven; sck_o = 0.
REQ-021 SEL/LO -> HI:
  - sck_o = 1.
  - On HI entry, when cmd_ien=1, W bits of sio_i are shifted into the read register.
  - Single mode samples sio_i[1]; dual samples [1:0]; quad samples [3:0]; the highest index is the earlier bit.
REQ-022 HI -> LO with sck_o = 0 and the next W bits driven, while periods remain; after the Nth HI, go to HOLD.
REQ-023 HOLD keeps sck_o low for cfg_div+1 cycles, then:
  - cmd_end = 1: ssn_o all ones, go to IDLE.
  - cmd_end = 0: go to WAIT with ssn held asserted.
REQ-024 In WAIT, an accepted command goes directly to LO-equivalent data setup (no SEL) and keeps the current ssn_o; a different cmd_ssn in WAIT is ignored until release.
REQ-025 sio_t and sio_o by mode:
  - Single: sio_t = {0, 0, 1, ~oen} and sio_o[3:2] = 2'b11.
  - Dual: sio_t = {0, 0, ~oen, ~oen}.
  - Quad: sio_t = {4{~oen}}.
  - sio_o data bits are don't-care when oen = 0.
REQ-026 sck_t = 0 from reset release; sck_t is never tri-stated after reset.
REQ-027 On HOLD exit, when cmd_ien = 1: rdt_vld = 1 with the 8*(cmd_len+1) captured bits right-aligned, upper bits zero.
REQ-028 rdt_vld stays high, with rdt_dat stable, until rdt_rdy.
REQ-029 No new command is accepted while rdt_vld = 1.
REQ-030 cmd_dat bits beyond the length are ignored.
REQ-031 Bits leave MSB-first: quad byte 0xA5 drives sio_o = 0xA, then 0x5.

Reset
REQ-032 While rst_n = 0, whether asserted mid-transfer or not:
  - FSM = IDLE.
  - sck_o = 0, sck_t = 0.
  - ssn_o = all ones, ssn_t = all zeros.
  - sio_o = 4'b1100, sio_t = 4'b0011.
  - cmd_rdy = 0, rdt_vld = 0, rdt_dat = 0.
  - Counters cleared.
REQ-033 cmd_rdy rises the first clk after rst_n deasserts; an aborted transfer produces no rdt_vld.

Verification
REQ-034 Single write 0xA5, cfg_div = 0, ssn 0x01, end = 1 -> MOSI sequence 1,0,1,0,0,1,0,1; 8 SCK pulses each 2 clk period; ssn_o = 0xFE then 0xFF.
REQ-035 Quad read, cmd_len = 1, oen = 0, ien = 1, slave drives 0x1,0x2,0x3,0x4 -> sio_t = 0xF; rdt_dat = 0x00001234.
REQ-036 Two commands, first end = 0 -> ssn stays low between them, no SEL phase on the second.
REQ-037 Read with rdt_rdy held low for 20 cycles -> rdt_dat stable; cmd_rdy low until the handshake.
REQ-038 rst_n pulsed low during the 3rd SCK period of a dual write -> the REQ-032 values hold on the same edge; no rdt_vld.
REQ-039 cfg_div = 3 -> SCK high and low phases each last exactly 4 clk.
